// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master that polls the image-processor message port, parses
// 3-word bounding-box messages and strobes them out to rover control.
module imgproc_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter logic [23:0] MSG_ID        = 24'h524242,
  parameter logic [2:0]  ADDR_STATUS   = 3'd0,
  parameter logic [2:0]  ADDR_MSG      = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        flush_req,
  output logic        bb_valid,
  output logic [10:0] bb_x_min,
  output logic [10:0] bb_y_min,
  output logic [10:0] bb_x_max,
  output logic [10:0] bb_y_max,
  output logic        bb_empty,
  output logic [15:0] msg_count,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STAT_RD,
    ST_STAT_WT,
    ST_MSG_RD,
    ST_MSG_WT,
    ST_DONE
  } state_t;

  localparam logic [31:0] TIMER_LOAD = 32'(POLL_INTERVAL - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] timer;
  logic        flush_pend;
  logic [7:0]  avail;
  logic [1:0]  idx;
  logic [10:0] x_min_q;
  logic [10:0] y_min_q;
  logic [7:0]  stat_words;
  logic        id_ok;
  logic [10:0] word_x;
  logic [10:0] word_y;

  assign stat_words = m_readdata[15:8];
  assign id_ok      = (m_readdata[23:0] == MSG_ID) && (m_readdata[31:24] == 8'h00);
  assign word_x     = m_readdata[26:16];
  assign word_y     = m_readdata[10:0];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    bb_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flush_pend)       state_next = ST_FLUSH;
        else if (timer == '0) state_next = ST_STAT_RD;
      end
      ST_FLUSH: begin
        m_write     = 1'b1;
        m_address   = ADDR_STATUS;
        m_writedata = 32'h0000_0010;
        state_next  = ST_STAT_RD;
      end
      ST_STAT_RD: begin
        m_read     = 1'b1;
        m_address  = ADDR_STATUS;
        state_next = ST_STAT_WT;
      end
      ST_STAT_WT: begin
        state_next = (stat_words >= 8'd3) ? ST_MSG_RD : ST_IDLE;
      end
      ST_MSG_RD: begin
        m_read     = 1'b1;
        m_address  = ADDR_MSG;
        state_next = ST_MSG_WT;
      end
      ST_MSG_WT: begin
        case (idx)
          2'd0:    state_next = id_ok ? ST_MSG_RD : ST_STAT_RD;
          2'd1:    state_next = ST_MSG_RD;
          default: state_next = ST_DONE;
        endcase
      end
      ST_DONE: begin
        bb_valid   = 1'b1;
        state_next = (avail >= 8'd3) ? ST_MSG_RD : ST_STAT_RD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign m_chipselect = m_read | m_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= TIMER_LOAD;
      flush_pend <= 1'b0;
      avail      <= '0;
      idx        <= '0;
      x_min_q    <= '0;
      y_min_q    <= '0;
      bb_x_min   <= '0;
      bb_y_min   <= '0;
      bb_x_max   <= '0;
      bb_y_max   <= '0;
      bb_empty   <= 1'b0;
      msg_count  <= '0;
      err_count  <= '0;
    end else begin
      // a request arriving in the FLUSH cycle itself stays pending
      flush_pend <= flush_req | (flush_pend & (state != ST_FLUSH));
      case (state)
        ST_IDLE: begin
          if (!flush_pend && timer != '0) timer <= timer - 32'd1;
        end
        ST_FLUSH: timer <= TIMER_LOAD;
        ST_STAT_WT: begin
          avail <= stat_words;
          idx   <= 2'd0;
          if (stat_words < 8'd3) timer <= TIMER_LOAD;
        end
        ST_MSG_WT: begin
          if (avail != '0) avail <= avail - 8'd1;
          case (idx)
            2'd0: begin
              if (!id_ok) begin
                if (err_count != '1) err_count <= err_count + 8'd1;
              end else begin
                idx <= 2'd1;
              end
            end
            2'd1: begin
              x_min_q <= word_x;
              y_min_q <= word_y;
              idx     <= 2'd2;
            end
            default: begin
              // outputs land on the edge entering DONE so they align with bb_valid
              bb_x_min <= x_min_q;
              bb_y_min <= y_min_q;
              bb_x_max <= word_x;
              bb_y_max <= word_y;
              bb_empty <= (x_min_q > word_x) || (y_min_q > word_y);
            end
          endcase
        end
        ST_DONE: begin
          idx <= 2'd0;
          if (msg_count != '1) msg_count <= msg_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Directed bench for imgproc_msg_reader with a behavioural message-FIFO slave.
module tb_imgproc_msg_reader;

  localparam int P = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
  logic        flush_req = 1'b0;
  logic        bb_valid;
  logic [10:0] bb_x_min, bb_y_min, bb_x_max, bb_y_max;
  logic        bb_empty;
  logic [15:0] msg_count;
  logic [7:0]  err_count;

  imgproc_msg_reader #(.POLL_INTERVAL(P)) dut (
    .clk(clk), .reset(reset),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .flush_req(flush_req),
    .bb_valid(bb_valid), .bb_x_min(bb_x_min), .bb_y_min(bb_y_min),
    .bb_x_max(bb_x_max), .bb_y_max(bb_y_max), .bb_empty(bb_empty),
    .msg_count(msg_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave model and monitor, all on the falling edge
  int          cyc = 0;
  logic [31:0] fifo[$];
  int          stat_q[$];
  int          msg_q[$];
  int          msg_n = 0, bb_n = 0, wr_n = 0, proto_err = 0;
  int          bb_cyc = 0, wr_cyc = 0, stat_after_wr = -1;
  logic        wr_seen = 1'b0;
  logic [31:0] wr_data = '0;
  logic [2:0]  wr_addr = '0;
  logic        prev_read = 1'b0;
  logic [7:0]  sz8;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (m_chipselect !== (m_read | m_write)) proto_err++;
      if (m_read && m_write) proto_err++;
      if (m_read && prev_read) proto_err++;
    end
    prev_read = (m_read === 1'b1);
    if (m_read === 1'b1 && m_address == 3'd0) begin
      stat_q.push_back(cyc);
      if (wr_seen) begin stat_after_wr = cyc; wr_seen = 1'b0; end
      sz8 = 8'(fifo.size());
      m_readdata <= {16'h0, sz8, 8'h00};
    end
    if (m_read === 1'b1 && m_address == 3'd1) begin
      msg_n++;
      msg_q.push_back(cyc);
      if (fifo.size() > 0) m_readdata <= fifo.pop_front();
      else                 m_readdata <= '0;
    end
    if (m_write === 1'b1) begin
      wr_n++;
      wr_cyc  = cyc;
      wr_data = m_writedata;
      wr_addr = m_address;
      wr_seen = 1'b1;
      if (m_address == 3'd0 && m_writedata[4]) fifo.delete();
    end
    if (bb_valid === 1'b1) begin
      bb_n++;
      bb_cyc = cyc;
    end
  end

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return stat_q.size();
      1:       return msg_n;
      2:       return bb_n;
      default: return wr_n;
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (cnt_of(sel) < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(cnt_of(sel) >= target), 32'd1);
  endtask

  task automatic push_msg(input logic [10:0] x0, input logic [10:0] y0,
                          input logic [10:0] x1, input logic [10:0] y1);
    fifo.push_back(32'h0052_4242);
    fifo.push_back({5'd0, x0, 5'd0, y0});
    fifo.push_back({5'd0, x1, 5'd0, y1});
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic check_box(input string tag, input int x0, input int y0,
                           input int x1, input int y1, input logic e);
    check({tag, "_xmin"}, 32'(bb_x_min), 32'(x0));
    check({tag, "_ymin"}, 32'(bb_y_min), 32'(y0));
    check({tag, "_xmax"}, 32'(bb_x_max), 32'(x1));
    check({tag, "_ymax"}, 32'(bb_y_max), 32'(y1));
    check({tag, "_empty"}, 32'(bb_empty), 32'(e));
  endtask

  int s0, m0, b0, w0, r_cyc;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(m_chipselect), 0);
    check("rst_rd_wr", {30'd0, m_read, m_write}, 0);
    check("rst_addr_wdata", m_writedata | 32'(m_address), 0);
    check("rst_bb_valid", 32'(bb_valid), 0);
    check("rst_counts", {8'd0, msg_count, err_count}, 0);

    // T1: basic message, latency, counters
    push_msg(11'd16, 11'd32, 11'd100, 11'd200);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cnt(2, 1, 300, "t1_bb_seen");
    check_box("t1", 16, 32, 100, 200, 1'b0);
    check("t1_msg_count", 32'(msg_count), 1);
    check("t1_latency", 32'(bb_cyc - msg_q[msg_q.size()-3]), 6);
    check("t1_bb_once", 32'(bb_n), 1);

    // T2: inverted box with reserved bits set -> empty
    fifo.push_back(32'h0052_4242);
    fifo.push_back(32'hFA7F_F9DF);
    fifo.push_back(32'h0000_0000);
    wait_cnt(2, 2, 300, "t2_bb_seen");
    check_box("t2", 639, 479, 0, 0, 1'b1);
    check("t2_msg_count", 32'(msg_count), 2);

    // T4: status 6, bad ID word first, then a good message, 2 words left over
    fifo.push_back(32'h0052_4243);
    push_msg(11'd1, 11'd2, 11'd3, 11'd4);
    fifo.push_back(32'hDEAD_0000);
    fifo.push_back(32'h1234_5678);
    wait_cnt(2, 3, 300, "t4_bb_seen");
    check("t4_err_count", 32'(err_count), 1);
    check("t4_msg_count", 32'(msg_count), 3);
    check_box("t4", 1, 2, 3, 4, 1'b0);

    // T3: status 2 -> no message reads, re-poll P+2 cycles after previous poll
    s0 = stat_q.size();
    m0 = msg_n;
    wait_cnt(0, s0 + 2, 200, "t3_polls_seen");
    if (stat_q.size() >= s0 + 2)
      check("t3_poll_gap", 32'(stat_q[s0+1] - stat_q[s0]), 32'(P + 2));
    check("t3_no_msg_rd", 32'(msg_n - m0), 0);

    // T5a: flush from idle -> one write of 0x10 to addr 0, then status read
    w0 = wr_n;
    pulse_flush();
    wait_cnt(3, w0 + 1, 200, "t5a_write_seen");
    check("t5a_wdata", wr_data, 32'h10);
    check("t5a_waddr", 32'(wr_addr), 0);
    @(posedge clk); #1;
    check("t5a_stat_after", 32'(stat_after_wr - wr_cyc), 1);

    // T5b: flush mid-message completes the message first
    w0 = wr_n;
    b0 = bb_n;
    m0 = msg_n;
    push_msg(11'd5, 11'd6, 11'd7, 11'd8);
    wait_cnt(1, m0 + 1, 200, "t5b_msg_started");
    pulse_flush();
    wait_cnt(2, b0 + 1, 100, "t5b_bb_seen");
    check_box("t5b", 5, 6, 7, 8, 1'b0);
    wait_cnt(3, w0 + 1, 100, "t5b_write_seen");
    check("t5b_order", 32'(bb_cyc < wr_cyc), 1);
    check("t5b_wdata", wr_data, 32'h10);
    @(posedge clk); #1;
    check("t5b_stat_after", 32'(stat_after_wr - wr_cyc), 1);
    check("t5b_one_write", 32'(wr_n - w0), 1);

    // T6: reset during MSG_WT idx1
    m0 = msg_n;
    b0 = bb_n;
    push_msg(11'd9, 11'd10, 11'd11, 11'd12);
    wait_cnt(1, m0 + 2, 200, "t6_second_rd");
    reset = 1'b1;
    @(posedge clk); #1;
    r_cyc = cyc;
    reset = 1'b0;
    @(negedge clk);
    check("t6_cs", 32'(m_chipselect), 0);
    check("t6_bb_valid", 32'(bb_valid), 0);
    check("t6_counts", {8'd0, msg_count, err_count}, 0);
    check("t6_bb_regs", {bb_x_min, bb_y_min, bb_x_max[9:0]} | 32'(bb_y_max) | 32'(bb_empty), 0);
    s0 = stat_q.size();
    wait_cnt(0, s0 + 1, 100, "t6_poll_seen");
    if (stat_q.size() >= s0 + 1)
      check("t6_poll_delay", 32'(stat_q[s0] - r_cyc), 32'(P));
    check("t6_no_bb", 32'(bb_n - b0), 0);

    check("protocol", 32'(proto_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
